// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select and load funct3.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'b00,
    WB_SRC_MEM = 2'b01,
    WB_SRC_PC4 = 2'b10,
    WB_SRC_CSR = 2'b11
  } wb_src_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } ld_f3_e;

endpackage

// File: rtl/wb_stage_pipe_load_extender.sv
// Sub-word load extraction: shift the aligned word down to the addressed byte,
// then sign/zero-extend. Flags misaligned or illegal loads (data forced to 0).
module load_extender
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] byte_off,
  output logic [XLEN-1:0]  data,
  output logic             fault
);

  logic [XLEN-1:0] shifted;
  assign shifted = raw >> {byte_off, 3'b000};

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = XLEN'($signed(shifted[7:0]));
      F3_LBU: data = XLEN'(shifted[7:0]);
      F3_LH: begin
        fault = byte_off[0];
        data  = XLEN'($signed(shifted[15:0]));
      end
      F3_LHU: begin
        fault = byte_off[0];
        data  = XLEN'(shifted[15:0]);
      end
      F3_LW: begin
        fault = byte_off[1:0] != 2'b00;
        data  = XLEN'($signed(shifted[31:0]));
      end
      // Doubleword and unsigned-word loads only exist on the 64-bit datapath.
      F3_LWU: begin
        fault = (XLEN != 64) || (byte_off[1:0] != 2'b00);
        data  = XLEN'(shifted[31:0]);
      end
      F3_LD: begin
        fault = (XLEN != 64) || (byte_off != '0);
        data  = shifted;
      end
      default: fault = 1'b1;
    endcase
    if (fault) data = '0;
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage: result-source mux, load extraction, x0/fault write suppression,
// one-cycle output register with flush/stall, and a retired-instruction counter.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int CNT_W = 64,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  mem_wb_dmem_data_out,
  input  logic [XLEN-1:0]  mem_wb_alu_result,
  input  logic [XLEN-1:0]  mem_wb_pc_plus4,
  input  logic [XLEN-1:0]  mem_wb_csr_rdata,
  input  logic [4:0]       mem_wb_rd_addr,
  input  logic             mem_wb_reg_write_en,
  input  logic [1:0]       mem_wb_mem_to_reg,
  input  logic [2:0]       mem_wb_load_funct3,
  input  logic [OFF_W-1:0] mem_wb_byte_off,
  output logic             wb_valid,
  output logic [4:0]       wb_rd_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_reg_write_en,
  output logic             wb_load_fault,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0] ld_data, sel_data;
  logic            ld_fault, fault;

  load_extender #(.XLEN(XLEN), .OFF_W(OFF_W)) u_ld (
    .raw      (mem_wb_dmem_data_out),
    .funct3   (mem_wb_load_funct3),
    .byte_off (mem_wb_byte_off),
    .data     (ld_data),
    .fault    (ld_fault)
  );

  // Only the MEM source can fault; funct3/byte_off are don't-care otherwise.
  assign fault = (mem_wb_mem_to_reg == WB_SRC_MEM) & ld_fault;

  always_comb begin
    sel_data = mem_wb_alu_result;
    case (mem_wb_mem_to_reg)
      WB_SRC_MEM: sel_data = ld_data;
      WB_SRC_PC4: sel_data = mem_wb_pc_plus4;
      WB_SRC_CSR: sel_data = mem_wb_csr_rdata;
      default:    sel_data = mem_wb_alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid        <= 1'b0;
      wb_rd_addr      <= '0;
      wb_data         <= '0;
      wb_reg_write_en <= 1'b0;
      wb_load_fault   <= 1'b0;
      instret         <= '0;
    end else if (flush) begin
      wb_valid        <= 1'b0;
      wb_reg_write_en <= 1'b0;
      wb_load_fault   <= 1'b0;
    end else if (stall) begin
      // Fault is a pulse; holding it through a stall would report the trap twice.
      wb_load_fault   <= 1'b0;
    end else begin
      wb_valid        <= in_valid;
      wb_rd_addr      <= mem_wb_rd_addr;
      wb_data         <= sel_data;
      wb_reg_write_en <= in_valid & mem_wb_reg_write_en & (mem_wb_rd_addr != 5'd0) & ~fault;
      wb_load_fault   <= in_valid & fault;
      if (in_valid && !fault) instret <= instret + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed-vector bench with a scoreboard: the driver queues expected outputs,
// a negedge monitor pops and compares them against two DUTs (32-bit and 64-bit).
module tb_wb_stage_pipe;

  typedef struct {
    logic        v, st, fl;
    logic [1:0]  m2r;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] raw, alu, pc4, csr;
    logic [4:0]  rd;
    logic        we;
  } stim_t;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        flt;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance, narrow counter to exercise wrap
  logic        a_v, a_st, a_fl, a_we;
  logic [31:0] a_raw, a_alu, a_pc4, a_csr;
  logic [4:0]  a_rd;
  logic [1:0]  a_m2r;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic        a_wb_valid, a_wb_we, a_wb_flt;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;
  logic [3:0]  a_instret;

  wb_stage_pipe #(.XLEN(32), .CNT_W(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(a_v), .stall(a_st), .flush(a_fl),
    .mem_wb_dmem_data_out(a_raw), .mem_wb_alu_result(a_alu),
    .mem_wb_pc_plus4(a_pc4), .mem_wb_csr_rdata(a_csr),
    .mem_wb_rd_addr(a_rd), .mem_wb_reg_write_en(a_we),
    .mem_wb_mem_to_reg(a_m2r), .mem_wb_load_funct3(a_f3), .mem_wb_byte_off(a_off),
    .wb_valid(a_wb_valid), .wb_rd_addr(a_wb_rd), .wb_data(a_wb_data),
    .wb_reg_write_en(a_wb_we), .wb_load_fault(a_wb_flt), .instret(a_instret)
  );

  logic        b_v, b_st, b_fl, b_we;
  logic [63:0] b_raw, b_alu, b_pc4, b_csr;
  logic [4:0]  b_rd;
  logic [1:0]  b_m2r;
  logic [2:0]  b_f3;
  logic [2:0]  b_off;
  logic        b_wb_valid, b_wb_we, b_wb_flt;
  logic [4:0]  b_wb_rd;
  logic [63:0] b_wb_data;
  logic [7:0]  b_instret;

  wb_stage_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(b_v), .stall(b_st), .flush(b_fl),
    .mem_wb_dmem_data_out(b_raw), .mem_wb_alu_result(b_alu),
    .mem_wb_pc_plus4(b_pc4), .mem_wb_csr_rdata(b_csr),
    .mem_wb_rd_addr(b_rd), .mem_wb_reg_write_en(b_we),
    .mem_wb_mem_to_reg(b_m2r), .mem_wb_load_funct3(b_f3), .mem_wb_byte_off(b_off),
    .wb_valid(b_wb_valid), .wb_rd_addr(b_wb_rd), .wb_data(b_wb_data),
    .wb_reg_write_en(b_wb_we), .wb_load_fault(b_wb_flt), .instret(b_instret)
  );

  exp_t q32[$];
  exp_t q64[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input exp_t e, input logic v, input logic [4:0] rd,
                     input logic [63:0] d, input logic we, input logic f,
                     input logic [7:0] c);
    n_vec++;
    if (v !== e.valid || rd !== e.rd || d !== e.data || we !== e.we ||
        f !== e.flt || c !== e.cnt) begin
      n_err++;
      $display("FAIL %s: got v=%b rd=%0d data=%h we=%b flt=%b cnt=%0d, exp v=%b rd=%0d data=%h we=%b flt=%b cnt=%0d",
               e.name, v, rd, d, we, f, c, e.valid, e.rd, e.data, e.we, e.flt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (q32.size() > 0)
      chk(q32.pop_front(), a_wb_valid, a_wb_rd, {32'd0, a_wb_data}, a_wb_we, a_wb_flt, {4'd0, a_instret});
    if (q64.size() > 0)
      chk(q64.pop_front(), b_wb_valid, b_wb_rd, b_wb_data, b_wb_we, b_wb_flt, b_instret);
  end

  task automatic drive32(input stim_t s);
    a_v = s.v; a_st = s.st; a_fl = s.fl; a_m2r = s.m2r; a_f3 = s.f3; a_off = s.off[1:0];
    a_raw = s.raw[31:0]; a_alu = s.alu[31:0]; a_pc4 = s.pc4[31:0]; a_csr = s.csr[31:0];
    a_rd = s.rd; a_we = s.we;
  endtask

  task automatic step32(input stim_t s, input exp_t e);
    drive32(s);
    q32.push_back(e);
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic step64(input stim_t s, input exp_t e);
    b_v = s.v; b_st = s.st; b_fl = s.fl; b_m2r = s.m2r; b_f3 = s.f3; b_off = s.off;
    b_raw = s.raw; b_alu = s.alu; b_pc4 = s.pc4; b_csr = s.csr; b_rd = s.rd; b_we = s.we;
    q64.push_back(e);
    @(posedge clk); @(negedge clk); #1;
  endtask

  localparam logic [63:0] RAW = 64'h80FF1234;

  initial begin
    stim_t idle;
    idle = '{0, 0, 0, 2'b00, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 5'd0, 0};
    drive32(idle);
    b_v = 0; b_st = 0; b_fl = 0; b_m2r = 0; b_f3 = 0; b_off = 0;
    b_raw = 0; b_alu = 0; b_pc4 = 0; b_csr = 0; b_rd = 0; b_we = 0;

    // reset state
    q32.push_back('{"reset32", 0, 5'd0, 64'd0, 0, 0, 8'd0});
    q64.push_back('{"reset64", 0, 5'd0, 64'd0, 0, 0, 8'd0});
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;

    step32('{1, 0, 0, 2'b01, 3'b000, 3'd3, RAW, 64'd0, 64'd0, 64'd0, 5'd5, 1},
           '{"lb_sext", 1, 5'd5, 64'hFFFFFF80, 1, 0, 8'd1});
    step32('{1, 0, 0, 2'b01, 3'b101, 3'd2, RAW, 64'd0, 64'd0, 64'd0, 5'd6, 1},
           '{"lhu", 1, 5'd6, 64'h000080FF, 1, 0, 8'd2});
    step32('{1, 0, 0, 2'b01, 3'b100, 3'd2, RAW, 64'd0, 64'd0, 64'd0, 5'd6, 1},
           '{"lbu", 1, 5'd6, 64'h000000FF, 1, 0, 8'd3});
    step32('{1, 0, 0, 2'b01, 3'b010, 3'd2, RAW, 64'd0, 64'd0, 64'd0, 5'd7, 1},
           '{"lw_misalign", 1, 5'd7, 64'd0, 0, 1, 8'd3});
    step32('{1, 0, 0, 2'b10, 3'b000, 3'd0, RAW, 64'd0, 64'h104, 64'd0, 5'd0, 1},
           '{"pc4_x0", 1, 5'd0, 64'h104, 0, 0, 8'd4});
    step32('{1, 0, 0, 2'b11, 3'b111, 3'd1, RAW, 64'd0, 64'd0, 64'hDEAD, 5'd3, 1},
           '{"csr_ignores_f3", 1, 5'd3, 64'hDEAD, 1, 0, 8'd5});
    step32('{1, 0, 0, 2'b01, 3'b001, 3'd2, RAW, 64'd0, 64'd0, 64'd0, 5'd8, 1},
           '{"lh_sext", 1, 5'd8, 64'hFFFF80FF, 1, 0, 8'd6});
    step32('{1, 0, 0, 2'b01, 3'b011, 3'd0, RAW, 64'd0, 64'd0, 64'd0, 5'd9, 1},
           '{"ld_illegal32", 1, 5'd9, 64'd0, 0, 1, 8'd6});
    step32('{1, 0, 0, 2'b00, 3'b000, 3'd0, RAW, 64'h55, 64'd0, 64'd0, 5'd2, 1},
           '{"alu", 1, 5'd2, 64'h55, 1, 0, 8'd7});
    step32('{1, 1, 0, 2'b00, 3'b000, 3'd0, RAW, 64'h99, 64'd0, 64'd0, 5'd9, 1},
           '{"stall1", 1, 5'd2, 64'h55, 1, 0, 8'd7});
    step32('{1, 1, 0, 2'b10, 3'b000, 3'd0, RAW, 64'h0, 64'h200, 64'd0, 5'd11, 1},
           '{"stall2", 1, 5'd2, 64'h55, 1, 0, 8'd7});
    step32('{1, 1, 0, 2'b01, 3'b010, 3'd2, RAW, 64'h0, 64'd0, 64'd0, 5'd12, 1},
           '{"stall3_fault_in", 1, 5'd2, 64'h55, 1, 0, 8'd7});

    // async reset mid-stall: raised after the edge, checked before the next one
    a_v = 1; a_st = 1;
    q32.push_back('{"async_reset", 0, 5'd0, 64'd0, 0, 0, 8'd0});
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;

    step32('{1, 0, 0, 2'b00, 3'b000, 3'd0, RAW, 64'hAA, 64'd0, 64'd0, 5'd2, 1},
           '{"alu_after_rst", 1, 5'd2, 64'hAA, 1, 0, 8'd1});
    step32('{1, 1, 1, 2'b00, 3'b000, 3'd0, RAW, 64'h77, 64'd0, 64'd0, 5'd3, 1},
           '{"flush_stall", 0, 5'd2, 64'hAA, 0, 0, 8'd1});
    step32('{1, 0, 0, 2'b01, 3'b010, 3'd1, RAW, 64'h0, 64'd0, 64'd0, 5'd10, 1},
           '{"lw_fault2", 1, 5'd10, 64'd0, 0, 1, 8'd1});
    step32('{1, 1, 0, 2'b00, 3'b000, 3'd0, RAW, 64'h66, 64'd0, 64'd0, 5'd4, 1},
           '{"stall_clears_fault", 1, 5'd10, 64'd0, 0, 0, 8'd1});
    step32('{1, 0, 1, 2'b00, 3'b000, 3'd0, RAW, 64'h66, 64'd0, 64'd0, 5'd4, 1},
           '{"flush_only", 0, 5'd10, 64'd0, 0, 0, 8'd1});
    for (int k = 1; k <= 15; k++)
      step32('{1, 0, 0, 2'b00, 3'b000, 3'd0, RAW, 64'(k), 64'd0, 64'd0, 5'd1, 1},
             '{$sformatf("wrap%0d", k), 1, 5'd1, 64'(k), 1, 0, 8'((1 + k) % 16)});
    drive32(idle);

    step64('{1, 0, 0, 2'b01, 3'b011, 3'd0, 64'h8000000000000001, 0, 0, 0, 5'd1, 1},
           '{"ld64", 1, 5'd1, 64'h8000000000000001, 1, 0, 8'd1});
    step64('{1, 0, 0, 2'b01, 3'b110, 3'd0, 64'h00000000FFFFFFFF, 0, 0, 0, 5'd2, 1},
           '{"lwu64", 1, 5'd2, 64'h00000000FFFFFFFF, 1, 0, 8'd2});
    step64('{1, 0, 0, 2'b01, 3'b010, 3'd0, 64'h0000000080000000, 0, 0, 0, 5'd3, 1},
           '{"lw64_sext", 1, 5'd3, 64'hFFFFFFFF80000000, 1, 0, 8'd3});
    step64('{1, 0, 0, 2'b01, 3'b011, 3'd4, 64'h8000000000000001, 0, 0, 0, 5'd4, 1},
           '{"ld64_misalign", 1, 5'd4, 64'd0, 0, 1, 8'd3});
    step64('{1, 0, 0, 2'b01, 3'b110, 3'd4, 64'h1234567800000000, 0, 0, 0, 5'd5, 1},
           '{"lwu64_off4", 1, 5'd5, 64'h0000000012345678, 1, 0, 8'd4});
    step64('{1, 0, 0, 2'b01, 3'b000, 3'd7, 64'h8000000000000001, 0, 0, 0, 5'd6, 1},
           '{"lb64_off7", 1, 5'd6, 64'hFFFFFFFFFFFFFF80, 1, 0, 8'd5});

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised next-generation writeback stage.
- Selects the writeback result from four sources: ALU, load data, PC+4, CSR.
- Extracts and sign/zero-extends sub-word load data, suppresses writes to x0 and faulting loads, and registers the result with stall/flush control.
- Sits after the MEM/WB boundary, drives the register-file write port and forwarding network, and keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 and 64.
- CNT_W, 64, width of instret counter.
- OFF_W, $clog2(XLEN/8), load byte-offset width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  MEM/WB slot holds a real instruction.
- stall  in  1  hold registered outputs.
- flush  in  1  kill the instruction being captured.
- mem_wb_dmem_data_out  in  XLEN  raw aligned memory word.
- mem_wb_alu_result  in  XLEN  ALU result.
- mem_wb_pc_plus4  in  XLEN  link value for JAL/JALR.
- mem_wb_csr_rdata  in  XLEN  CSR read value.
- mem_wb_rd_addr  in  5  destination register.
- mem_wb_reg_write_en  in  1  instruction writes rd.
- mem_wb_mem_to_reg  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 CSR.
- mem_wb_load_funct3  in  3  load type.
- mem_wb_byte_off  in  OFF_W  low address bits of the load.
- wb_valid  out  1  registered slot valid.
- wb_rd_addr  out  5  registered rd.
- wb_data  out  XLEN  registered write data.
- wb_reg_write_en  out  1  registered regfile write strobe.
- wb_load_fault  out  1  one-cycle pulse on a misaligned or illegal load.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst=1): every output is 0; instret is 0.
- Latency: one cycle from MEM/WB inputs to the wb_* outputs.

Edge priority:
- rst, then flush, then stall, then capture.
- flush: wb_valid, wb_reg_write_en and wb_load_fault go to 0; wb_data and wb_rd_addr hold; instret does not change.
- stall without flush: all outputs hold, except wb_load_fault, which goes to 0 so it never repeats.
- Capture: wb_valid <= in_valid.
  - wb_reg_write_en <= in_valid & mem_wb_reg_write_en & (rd != 0) & ~fault.
  - wb_data <= selected value; wb_rd_addr <= rd.
  - wb_load_fault <= in_valid & (mem_to_reg == 01) & fault.

Load extraction (applies only when mem_to_reg = 01):
- Shift the raw word right by 8*byte_off, then extend.
- funct3 encodings: 000 LB sign-extend, 001 LH sign-extend, 010 LW sign-extend to XLEN, 100 LBU, 101 LHU.
- XLEN=64 only: 110 LWU, 011 LD.
- Any other funct3 is illegal: fault=1.
- Misaligned: LH/LHU with byte_off[0]=1, LW/LWU with byte_off[1:0]!=0, or LD with byte_off!=0 gives fault=1.
- On fault, data is 0 and the write is suppressed.

Other rules:
- Sources other than MEM never fault; funct3 and byte_off are ignored for them.
- instret increments by 1 on each capture edge with in_valid=1 and no fault, and wraps modulo 2^CNT_W.
- A faulting load still sets wb_valid=1 so that the trap logic can see the slot.
- Reset asserted mid-stall clears everything immediately; the stall does not persist.

Decomposition:
- Shared package wb_pkg:
  - MEM_TO_REG encodings (WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4, WB_SRC_CSR).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU).
- One combinational sub-module, load_extender (params XLEN, OFF_W).
  - Inputs: raw word, funct3, byte_off.
  - Outputs: extended data and fault.
- The source mux, pipeline register and counter stay in wb_stage_pipe.

Test Plan:
- Reset: rst=1 mid-run with wb_valid=1 and instret=7 -> all outputs 0 asynchronously; instret=0 after release.
- LB sign-extension: raw=0x80FF1234, byte_off=3, funct3=000, rd=5 -> next cycle wb_data=0xFFFFFF80, wb_reg_write_en=1, instret+1.
- LHU: byte_off=2, same raw -> wb_data=0x000080FF. LW with byte_off=2 -> wb_load_fault=1 for one cycle, wb_reg_write_en=0, wb_data=0, instret unchanged.
- x0 and source mux:
  - mem_to_reg=10, pc_plus4=0x104, rd=0 -> wb_data=0x104, wb_reg_write_en=0, wb_valid=1, instret+1.
  - mem_to_reg=11, csr=0xDEAD, rd=3 -> wb_data=0xDEAD.
- Stall then flush:
  - Capture ALU=0x55 into rd=2, then stall=1 for 3 cycles with changing inputs -> outputs held at 0x55 / rd 2, instret advanced once only.
  - Then flush=1 together with stall=1 -> wb_valid=0, wb_reg_write_en=0.
- Counter wrap and XLEN=64: with CNT_W=4, after 16 valid captures instret=0. With XLEN=64, LD with byte_off=0 passes 0x8000000000000001 unchanged; LWU of 0xFFFFFFFF gives 0x00000000FFFFFFFF.
